// File: rtl/l2_flatten_pkg.sv
// Shared definitions for the conv engine and the layer-2 flatten stage.
package l2_flatten_pkg;

    localparam int unsigned DATA_W_DEF = 20;
    localparam int unsigned ADDR_W_DEF = 12;

    // Shared result-bus memory selects
    localparam logic [2:0] CSEL_NONE  = 3'b000;
    localparam logic [2:0] CSEL_L0_K0 = 3'b001;
    localparam logic [2:0] CSEL_L0_K1 = 3'b010;
    localparam logic [2:0] CSEL_L1_K0 = 3'b011;
    localparam logic [2:0] CSEL_L1_K1 = 3'b100;
    localparam logic [2:0] CSEL_L2    = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_LAT  = 3'd2,
        ST_WR   = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    // Layer-1 map select for a given kernel index
    function automatic logic [2:0] l1_sel(input logic k);
        return k ? CSEL_L1_K1 : CSEL_L1_K0;
    endfunction

endpackage

// File: rtl/l2_flatten_addr_gen.sv
// Element/kernel counters and interleaved write-address formation.
module l2_addr_gen
    import l2_flatten_pkg::*;
#(
    parameter int unsigned N_ELEM  = 1024,
    parameter int unsigned NUM_KER = 2,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] rd_addr_nxt_c_o,
    output logic              k_nxt_c_o,
    output logic [ADDR_W-1:0] wr_addr_c_o,
    output logic              last_c_o
);

    localparam int unsigned IW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    logic [IW-1:0] i_q, i_d;
    logic          k_q, k_d;
    logic          i_last, k_last;

    assign i_last = (i_q == IW'(N_ELEM - 1));
    assign k_last = (k_q == 1'(NUM_KER - 1));

    // Next counter values: clear on start, step kernel then element on each write
    always_comb begin
        i_d = i_q;
        k_d = k_q;
        if (clr_i) begin
            i_d = '0;
            k_d = 1'b0;
        end else if (adv_i) begin
            if (!k_last) begin
                k_d = k_q + 1'b1;
            end else begin
                k_d = 1'b0;
                if (!i_last) begin
                    i_d = i_q + IW'(1);
                end
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_q <= '0;
            k_q <= 1'b0;
        end else begin
            i_q <= i_d;
            k_q <= k_d;
        end
    end

    assign rd_addr_nxt_c_o = ADDR_W'(i_d);
    assign k_nxt_c_o       = k_d;
    assign last_c_o        = i_last & k_last;

    // Two kernels interleave as {i,k}; a single kernel is a straight copy
    if (NUM_KER == 2) begin : g_wa_two
        assign wr_addr_c_o = ADDR_W'({i_q, k_q});
    end else begin : g_wa_one
        assign wr_addr_c_o = ADDR_W'(i_q);
    end

endmodule

// File: rtl/l2_flatten.sv
// Layer-2 flatten: copies layer-1 max-pooled maps into interleaved layer-2 memory.
module l2_flatten
    import l2_flatten_pkg::*;
#(
    parameter int unsigned N_ELEM  = 1024,
    parameter int unsigned NUM_KER = 2,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [2:0]        csel,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_rd,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic              cwr,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [DATA_W-1:0] cdata_wr
);

    state_t state_q, state_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [2:0]        csel_q, csel_d;
    logic              crd_q, crd_d;
    logic              cwr_q, cwr_d;
    logic [ADDR_W-1:0] caddr_rd_q, caddr_rd_d;
    logic [ADDR_W-1:0] caddr_wr_q, caddr_wr_d;
    logic [DATA_W-1:0] cdata_wr_q, cdata_wr_d;

    logic              clr, adv;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic              k_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic              last;

    assign clr = (state_q == ST_IDLE) && start;
    assign adv = (state_q == ST_WR);

    l2_addr_gen #(
        .N_ELEM (N_ELEM),
        .NUM_KER(NUM_KER),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk            (clk),
        .reset          (reset),
        .clr_i          (clr),
        .adv_i          (adv),
        .rd_addr_nxt_c_o(rd_addr_nxt),
        .k_nxt_c_o      (k_nxt),
        .wr_addr_c_o    (wr_addr),
        .last_c_o       (last)
    );

    // Next state and the bus values to be visible in that state
    always_comb begin
        state_d    = state_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        crd_d      = 1'b0;
        cwr_d      = 1'b0;
        csel_d     = CSEL_NONE;
        caddr_rd_d = caddr_rd_q;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RD;
                    busy_d     = 1'b1;
                    crd_d      = 1'b1;
                    csel_d     = l1_sel(k_nxt);
                    caddr_rd_d = rd_addr_nxt;
                end
            end
            ST_RD: begin
                state_d = ST_LAT;
                busy_d  = 1'b1;
                crd_d   = 1'b1;
                csel_d  = csel_q;
            end
            ST_LAT: begin
                state_d    = ST_WR;
                busy_d     = 1'b1;
                cwr_d      = 1'b1;
                csel_d     = CSEL_L2;
                caddr_wr_d = wr_addr;
                cdata_wr_d = cdata_rd;
            end
            ST_WR: begin
                if (last) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d    = ST_RD;
                    busy_d     = 1'b1;
                    crd_d      = 1'b1;
                    csel_d     = l1_sel(k_nxt);
                    caddr_rd_d = rd_addr_nxt;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bus-output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            csel_q     <= CSEL_NONE;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            csel_q     <= csel_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign csel     = csel_q;
    assign crd      = crd_q;
    assign cwr      = cwr_q;
    assign caddr_rd = caddr_rd_q;
    assign caddr_wr = caddr_wr_q;
    assign cdata_wr = cdata_wr_q;

endmodule

// File: tb/tb_l2_flatten.sv
// Directed bench for l2_flatten: two-kernel and single-kernel instances with a write scoreboard.
module tb_l2_flatten;
    import l2_flatten_pkg::*;

    typedef struct packed {
        logic [11:0] addr;
        logic [19:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_a = 1'b1, reset_b = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        busy_a, done_a, crd_a, cwr_a;
    logic        busy_b, done_b, crd_b, cwr_b;
    logic [2:0]  csel_a, csel_b;
    logic [11:0] caddr_rd_a, caddr_wr_a, caddr_rd_b, caddr_wr_b;
    logic [19:0] cdata_rd_a = '0, cdata_rd_b = '0;
    logic [19:0] cdata_wr_a, cdata_wr_b;

    int total = 0;
    int bad   = 0;
    int wr_cnt_a = 0, wr_cnt_b = 0;
    int done_cnt_a = 0, done_cnt_b = 0;
    logic [11:0] last_addr_a = '0, last_addr_b = '0;
    wr_t q_a[$];
    wr_t q_b[$];

    always #5 clk = ~clk;

    l2_flatten #(.N_ELEM(1024), .NUM_KER(2), .ADDR_W(12), .DATA_W(20)) u_dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .busy(busy_a), .done(done_a),
        .csel(csel_a), .crd(crd_a), .caddr_rd(caddr_rd_a), .cdata_rd(cdata_rd_a),
        .cwr(cwr_a), .caddr_wr(caddr_wr_a), .cdata_wr(cdata_wr_a)
    );

    l2_flatten #(.N_ELEM(1024), .NUM_KER(1), .ADDR_W(12), .DATA_W(20)) u_dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .busy(busy_b), .done(done_b),
        .csel(csel_b), .crd(crd_b), .caddr_rd(caddr_rd_b), .cdata_rd(cdata_rd_b),
        .cwr(cwr_b), .caddr_wr(caddr_wr_b), .cdata_wr(cdata_wr_b)
    );

    // Layer-1 memories: K0[i]=i, K1[i]=-i for A; K0[i]=FFFFF-i for B; junk on a wrong select
    always @(posedge clk) begin
        if (crd_a) begin
            case (csel_a)
                CSEL_L1_K0: cdata_rd_a <= 20'(caddr_rd_a);
                CSEL_L1_K1: cdata_rd_a <= 20'(0) - 20'(caddr_rd_a);
                default:    cdata_rd_a <= 20'h5A5A5;
            endcase
        end
        if (crd_b) begin
            cdata_rd_b <= (csel_b == CSEL_L1_K0) ? (20'hFFFFF - 20'(caddr_rd_b)) : 20'h5A5A5;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus protocol monitor and write scoreboard for both instances
    initial begin
        logic prev_done_a, prev_done_b;
        wr_t  e;
        prev_done_a = 1'b0;
        prev_done_b = 1'b0;
        forever begin
            @(negedge clk);
            chk("a_rd_wr_excl", 32'(crd_a & cwr_a), 32'd0);
            chk("b_rd_wr_excl", 32'(crd_b & cwr_b), 32'd0);
            if (!crd_a && !cwr_a) chk("a_csel_quiet", 32'(csel_a), 32'd0);
            if (!crd_b && !cwr_b) chk("b_csel_quiet", 32'(csel_b), 32'd0);
            chk("b_no_k1_sel", 32'(csel_b == CSEL_L1_K1), 32'd0);
            if (prev_done_a) chk("a_done_width", 32'(done_a), 32'd0);
            if (prev_done_b) chk("b_done_width", 32'(done_b), 32'd0);
            prev_done_a = done_a;
            prev_done_b = done_b;
            if (done_a) done_cnt_a++;
            if (done_b) done_cnt_b++;
            if (cwr_a) begin
                wr_cnt_a++;
                last_addr_a = caddr_wr_a;
                chk("a_wr_expected", 32'(q_a.size() != 0), 32'd1);
                if (q_a.size() != 0) begin
                    e = q_a.pop_front();
                    chk("a_wr_addr", 32'(caddr_wr_a), 32'(e.addr));
                    chk("a_wr_data", 32'(cdata_wr_a), 32'(e.data));
                end
            end
            if (cwr_b) begin
                wr_cnt_b++;
                last_addr_b = caddr_wr_b;
                chk("b_wr_expected", 32'(q_b.size() != 0), 32'd1);
                if (q_b.size() != 0) begin
                    e = q_b.pop_front();
                    chk("b_wr_addr", 32'(caddr_wr_b), 32'(e.addr));
                    chk("b_wr_data", 32'(cdata_wr_b), 32'(e.data));
                end
            end
        end
    end

    task automatic push_a();
        for (int i = 0; i < 1024; i++) begin
            q_a.push_back({12'(2 * i), 20'(i)});
            q_a.push_back({12'(2 * i + 1), 20'(0) - 20'(i)});
        end
    endtask

    // Pulse start on A and step cycle by cycle; optional re-start at cycle 100 or reset at rst_at
    task automatic run_a(input bit restart100, input int rst_at, output int done_n);
        int n;
        done_n = -1;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        n = 1;
        while (n <= 7000) begin
            if (n == 1) begin
                chk("c1_busy", 32'(busy_a), 32'd1);
                chk("c1_crd", 32'(crd_a), 32'd1);
                chk("c1_csel", 32'(csel_a), 32'(CSEL_L1_K0));
                chk("c1_caddr_rd", 32'(caddr_rd_a), 32'd0);
            end
            if (n == 2) chk("c2_lat_crd", 32'(crd_a), 32'd1);
            if (n == 3) begin
                chk("c3_cwr", 32'(cwr_a), 32'd1);
                chk("c3_csel", 32'(csel_a), 32'(CSEL_L2));
                chk("c3_caddr_wr", 32'(caddr_wr_a), 32'd0);
            end
            if (n == 4) begin
                chk("c4_csel", 32'(csel_a), 32'(CSEL_L1_K1));
                chk("c4_caddr_rd", 32'(caddr_rd_a), 32'd0);
            end
            if (restart100 && n == 99) start_a = 1'b1;
            if (restart100 && n == 100) start_a = 1'b0;
            if (rst_at > 0 && n == rst_at) begin
                reset_a = 1'b1;
                #1;
                chk("rst_busy", 32'(busy_a), 32'd0);
                chk("rst_strobes", 32'({crd_a, cwr_a, done_a}), 32'd0);
                chk("rst_csel", 32'(csel_a), 32'd0);
                return;
            end
            if (done_a) begin
                done_n = n;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int dn, wbase, dbase;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy0", 32'(busy_a), 32'd0);
        chk("rst_done0", 32'(done_a), 32'd0);
        chk("rst_bus0", 32'({csel_a, crd_a, cwr_a}), 32'd0);
        chk("rst_addr0", 32'({caddr_rd_a, caddr_wr_a}), 32'd0);
        chk("rst_wdata0", 32'(cdata_wr_a), 32'd0);
        chk("rst_b_busy0", 32'(busy_b), 32'd0);
        reset_a = 1'b0;
        reset_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Full two-kernel run with a start while busy, then start coincident with FIN
        push_a();
        wbase = wr_cnt_a;
        dbase = done_cnt_a;
        run_a(1'b1, 0, dn);
        chk("t1_done_cycle", 32'(dn), 32'd6145);
        start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        chk("t1_fin_start_ignored", 32'(busy_a), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("t1_still_idle", 32'({busy_a, crd_a, cwr_a}), 32'd0);
        chk("t1_writes", 32'(wr_cnt_a - wbase), 32'd2048);
        chk("t1_last_addr", 32'(last_addr_a), 32'd2047);
        chk("t1_queue_empty", 32'(q_a.size()), 32'd0);
        chk("t1_single_done", 32'(done_cnt_a - dbase), 32'd1);

        // Reset in the middle of a run, then a fresh complete run
        push_a();
        dbase = done_cnt_a;
        run_a(1'b0, 500, dn);
        q_a.delete();
        repeat (2) @(posedge clk);
        #1 reset_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t4_no_done", 32'(done_cnt_a - dbase), 32'd0);
        chk("t4_idle", 32'(busy_a), 32'd0);
        push_a();
        wbase = wr_cnt_a;
        run_a(1'b0, 0, dn);
        chk("t4_done_cycle", 32'(dn), 32'd6145);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_writes", 32'(wr_cnt_a - wbase), 32'd2048);
        chk("t4_queue_empty", 32'(q_a.size()), 32'd0);

        // Single-kernel copy of negative-looking data
        for (int i = 0; i < 1024; i++) q_b.push_back({12'(i), 20'hFFFFF - 20'(i)});
        wbase = wr_cnt_b;
        dn = -1;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int n = 1; n <= 4000; n++) begin
            if (done_b) begin
                dn = n;
                break;
            end
            @(posedge clk); #1;
        end
        chk("t5_done_cycle", 32'(dn), 32'd3073);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_writes", 32'(wr_cnt_b - wbase), 32'd1024);
        chk("t5_last_addr", 32'(last_addr_b), 32'd1023);
        chk("t5_queue_empty", 32'(q_b.size()), 32'd0);
        chk("t5_single_done", 32'(done_cnt_b), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
